// File: rtl/posit_div_pkg.sv
// Shared types and width helpers for the posit divider mantissa path.
package posit_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Quotient width: N+1 bits so a quotient in [1,2) keeps its leading bit.
    function automatic int unsigned QW(input int unsigned n);
        return n + 1;
    endfunction

    // Counter width: enough to hold N down to 0.
    function automatic int unsigned CW(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/posit_div_mant_seq_step.sv
// One restoring-division step: compare, conditionally subtract, emit quotient bit.
module div_restore_step #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] div_i,
    output logic         q_bit_o,
    output logic [W-1:0] rem_next_o
);

    // Subtract the divisor only when it fits into the partial remainder.
    always_comb begin
        q_bit_o    = (rem_i >= div_i);
        rem_next_o = q_bit_o ? (rem_i - div_i) : rem_i;
    end

endmodule

// File: rtl/posit_div_mant_seq.sv
// Sequential mantissa-quotient engine: N+1-step restoring divide, normalise,
// report exponent adjust and sticky, valid/ready on both sides.
module posit_div_mant_seq
    import posit_div_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   Mantissa1,
    input  logic [N-1:0]   Mantissa2,
    input  logic           Sign1,
    input  logic           Sign2,
    input  logic           inf1,
    input  logic           inf2,
    input  logic           zero1,
    input  logic           zero2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Div_Mant_N,
    output logic           mant_uflow,
    output logic           sticky,
    output logic           Sign,
    output logic           inf,
    output logic           zero
);

    localparam int unsigned QWID = QW(N);
    // ES carries no datapath weight; it is referenced only so the parameter
    // set stays aligned with the package types.
    localparam int unsigned CWID = CW(N) + 0 * ES;

    div_state_t        state_q, state_d;
    logic [CWID-1:0]   cnt_q, cnt_d;
    logic [QWID-1:0]   rem_q, rem_d;
    logic [QWID-1:0]   div_q, div_d;
    logic [N-1:0]      quo_q, quo_d;
    logic [2*N-1:0]    mant_q, mant_d;
    logic              uflow_q, uflow_d;
    logic              sticky_q, sticky_d;
    logic              sign_q, sign_d;
    logic              inf_q, inf_d;
    logic              zero_q, zero_d;

    logic              q_bit;
    logic [QWID-1:0]   rem_next;
    logic [QWID-1:0]   quo_full;
    logic              special;

    div_restore_step #(
        .W (QWID)
    ) u_step (
        .rem_i      (rem_q),
        .div_i      (div_q),
        .q_bit_o    (q_bit),
        .rem_next_o (rem_next)
    );

    // The top N quotient bits live in quo_q; the final bit is appended on the
    // last CALC edge, so the full N+1-bit quotient is only formed combinationally.
    assign quo_full = {quo_q, q_bit};
    assign special  = inf1 | inf2 | zero1 | zero2 | (Mantissa2 == '0);

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign Div_Mant_N = mant_q;
    assign mant_uflow = uflow_q;
    assign sticky     = sticky_q;
    assign Sign       = sign_q;
    assign inf        = inf_q;
    assign zero       = zero_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        mant_d   = mant_q;
        uflow_d  = uflow_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        inf_d    = inf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = Sign1 ^ Sign2;
                    zero_d = zero1 | zero2;
                    inf_d  = inf1 | inf2 | ((Mantissa2 == '0) & ~zero1);
                    div_d  = {1'b0, Mantissa2};
                    quo_d  = '0;
                    if (special) begin
                        mant_d   = '0;
                        uflow_d  = 1'b0;
                        sticky_d = 1'b0;
                        rem_d    = '0;
                        state_d  = DONE;
                    end else begin
                        rem_d   = {1'b0, Mantissa1};
                        cnt_d   = CWID'(N);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = {quo_q[N-2:0], q_bit};
                if (cnt_q != '0) begin
                    rem_d = {rem_next[N-1:0], 1'b0};
                    cnt_d = cnt_q - CWID'(1);
                end else begin
                    rem_d    = rem_next;
                    sticky_d = |rem_next;
                    if (quo_full[N]) begin
                        mant_d  = {quo_full, {(N-1){1'b0}}};
                        uflow_d = 1'b0;
                    end else begin
                        mant_d  = {quo_full[N-1:0], {N{1'b0}}};
                        uflow_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset dominates any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            mant_q   <= '0;
            uflow_q  <= 1'b0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            mant_q   <= mant_d;
            uflow_q  <= uflow_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_posit_div_mant_seq.sv
// Directed bench for posit_div_mant_seq at N=8.
module tb_posit_div_mant_seq;

    localparam int unsigned N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  Mantissa1;
    logic [N-1:0]  Mantissa2;
    logic          Sign1, Sign2, inf1, inf2, zero1, zero2;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] Div_Mant_N;
    logic          mant_uflow, sticky, Sign, inf, zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    posit_div_mant_seq #(
        .N  (8),
        .ES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Mantissa1  (Mantissa1),
        .Mantissa2  (Mantissa2),
        .Sign1      (Sign1),
        .Sign2      (Sign2),
        .inf1       (inf1),
        .inf2       (inf2),
        .zero1      (zero1),
        .zero2      (zero2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Div_Mant_N (Div_Mant_N),
        .mant_uflow (mant_uflow),
        .sticky     (sticky),
        .Sign       (Sign),
        .inf        (inf),
        .zero       (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand set at a negedge, accept it, then wait for out_valid.
    task automatic start_op(input logic [7:0] m1, input logic [7:0] m2,
                            input logic s1, input logic s2, input logic i1, input logic i2,
                            input logic z1, input logic z2, output int cyc);
        cyc = 0;
        Mantissa1 = m1; Mantissa2 = m2;
        Sign1 = s1; Sign2 = s2; inf1 = i1; inf2 = i2; zero1 = z1; zero2 = z2;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] m1, input logic [7:0] m2,
                          input logic s1, input logic s2, input logic i1, input logic i2,
                          input logic z1, input logic z2,
                          input logic [15:0] e_mant, input logic e_uf, input logic e_st,
                          input logic e_sign, input logic e_inf, input logic e_zero,
                          input int e_lat);
        int cyc;
        check({name, ".rdy_before"}, 32'(in_ready), 32'd1);
        start_op(m1, m2, s1, s2, i1, i2, z1, z2, cyc);
        check({name, ".latency"}, 32'(cyc), 32'(e_lat));
        check({name, ".mant"},    32'(Div_Mant_N), 32'(e_mant));
        check({name, ".uflow"},   32'(mant_uflow), 32'(e_uf));
        check({name, ".sticky"},  32'(sticky), 32'(e_st));
        check({name, ".sign"},    32'(Sign), 32'(e_sign));
        check({name, ".inf"},     32'(inf), 32'(e_inf));
        check({name, ".zero"},    32'(zero), 32'(e_zero));
        check({name, ".busy"},    32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({name, ".vld_after"},  32'(out_valid), 32'd0);
        check({name, ".rdy_after"},  32'(in_ready), 32'd1);
        check({name, ".mant_held"},  32'(Div_Mant_N), 32'(e_mant));
    endtask

    initial begin
        int cyc;
        logic seen_valid;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Mantissa1 = '0; Mantissa2 = '0;
        Sign1 = 0; Sign2 = 0; inf1 = 0; inf2 = 0; zero1 = 0; zero2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.in_ready",  32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.mant",      32'(Div_Mant_N), 32'd0);
        check("reset.flags",     32'({mant_uflow, sticky, Sign, inf, zero}), 32'd0);
        rst = 1'b0;

        // Normal quotients (values hand-computed as floor(M1*256/M2)).
        run_op("t1_80_80", 8'h80, 8'h80, 0, 0, 0, 0, 0, 0, 16'h8000, 0, 0, 0, 0, 0, 9);
        run_op("t2_80_C0", 8'h80, 8'hC0, 0, 0, 0, 0, 0, 0, 16'hAA00, 1, 1, 0, 0, 0, 9);
        // Specials right after a result with uflow/sticky set, so they must clear.
        run_op("t4_zero2", 8'h80, 8'h80, 0, 1, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0);
        run_op("t2b_80_C0", 8'h80, 8'hC0, 0, 0, 0, 0, 0, 0, 16'hAA00, 1, 1, 0, 0, 0, 9);
        run_op("t4_m2zero", 8'h80, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0);
        run_op("t4_both0",  8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 1, 0);
        run_op("t4_inf1",   8'h80, 8'h80, 1, 0, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 0);
        run_op("t3_FF_80",  8'hFF, 8'h80, 1, 0, 0, 0, 0, 0, 16'hFF00, 0, 0, 1, 0, 0, 9);
        run_op("t_C0_80",   8'hC0, 8'h80, 1, 1, 0, 0, 0, 0, 16'hC000, 0, 0, 0, 0, 0, 9);
        run_op("t_90_F0",   8'h90, 8'hF0, 0, 1, 0, 0, 0, 0, 16'h9900, 1, 1, 1, 0, 0, 9);
        run_op("t_80_FF",   8'h80, 8'hFF, 0, 0, 0, 0, 0, 0, 16'h8000, 1, 1, 0, 0, 0, 9);

        // Stall in DONE with in_valid pulses that must be ignored.
        start_op(8'hC0, 8'h80, 0, 0, 0, 0, 0, 0, cyc);
        check("t5.latency", 32'(cyc), 32'd9);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            Mantissa1 = 8'hA0 + 8'(i);
            Mantissa2 = 8'hE0;
            @(posedge clk); @(negedge clk);
            check("t5.hold_valid", 32'(out_valid), 32'd1);
            check("t5.hold_busy",  32'(in_ready), 32'd0);
            check("t5.hold_mant",  32'(Div_Mant_N), 32'hC000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("t5.release_vld", 32'(out_valid), 32'd0);
        check("t5.release_rdy", 32'(in_ready), 32'd1);
        check("t5.mant_kept",   32'(Div_Mant_N), 32'hC000);

        // Reset mid-CALC at cnt=4: accept sets cnt=8, four more edges bring it to 4.
        seen_valid = 1'b0;
        Mantissa1 = 8'h80; Mantissa2 = 8'hC0;
        Sign1 = 0; Sign2 = 0; inf1 = 0; inf2 = 0; zero1 = 0; zero2 = 0;
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_valid |= out_valid;
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        check("t6.idle_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            seen_valid |= out_valid;
            @(posedge clk); @(negedge clk);
        end
        check("t6.no_valid", 32'(seen_valid), 32'd0);
        run_op("t6_after", 8'h80, 8'hC0, 0, 0, 0, 0, 0, 0, 16'hAA00, 1, 1, 0, 0, 0, 9);

        // Reset beats an in_valid on the same edge.
        Mantissa1 = 8'hFF; Mantissa2 = 8'h80;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rstprio.rdy", 32'(in_ready), 32'd1);
        check("rstprio.mant", 32'(Div_Mant_N), 32'd0);

        // Reset while holding a result in DONE.
        start_op(8'h80, 8'h80, 0, 0, 0, 0, 0, 1, cyc);
        check("rstdone.valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rstdone.cleared", 32'(out_valid), 32'd0);
        check("rstdone.zero",    32'(zero), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
